dbg_led_capture: RTL and testbench
==================================

Name: dbg_led_capture

Overview:
Downstream consumer of the debug LED mux output; drives the physical 16-bit LED bank.
Passes the selected debug word through live, or freezes it on a PC-match trigger.
Keeps a circular history of the last DEPTH sampled words, browsable with a debounced push button.
Lets the board operator inspect pipeline state around a breakpoint without stopping the core clock.

Parameters:
DEPTH, 8, history entries; power of 2, 2..32
DEBOUNCE_CYCLES, 50000, cycles a button must be stable high before a press pulse is issued; >=2

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
led_in  in  16  debug word from LED mux
sample_en  in  1  one-cycle strobe: record led_in into history (e.g. instruction done)
trig_en  in  1  allows arming; 0 forces ARMED back to LIVE
trig_value  in  16  breakpoint PC
trig_pc  in  16  PC compared against trig_value
btn_mode  in  1  raw, asynchronous mode button
btn_step  in  1  raw, asynchronous step button
led_out  out  16  registered LED drive
state_out  out  2  0 LIVE, 1 ARMED, 2 CAPTURED, 3 BROWSE
hist_idx  out  log2(DEPTH)  entries back from newest being shown (0 = newest)
hist_count  out  log2(DEPTH)+1  valid history entries

Behaviour:
- Reset (rst=0 at a clk edge): led_out=0, state=LIVE, wptr=0, hist_count=0, hist_idx=0, synchronizer and debounce counters cleared. Applies mid-browse and mid-debounce; history RAM contents are don't-care.
- Button conditioning, per button:
  - 2-FF synchronizer, then counter that reloads on any level change.
  - A one-cycle press pulse fires once the synchronized level has stayed 1 for DEBOUNCE_CYCLES consecutive cycles.
  - Held button gives exactly one pulse; release re-arms.
  - Press latency from raw rise: DEBOUNCE_CYCLES+2 cycles.
- History write (LIVE and ARMED only):
  - On sample_en, mem[wptr]<=led_in; wptr<=wptr+1 mod DEPTH; hist_count saturates at DEPTH.
  - Oldest entry is overwritten when full.
- hit = sample_en & (trig_pc==trig_value).
- Mode and step presses change state even when they coincide with sample_en; the history write for that cycle still occurs if the state is LIVE or ARMED.
- LIVE:
  - led_out<=led_in (1-cycle latency).
  - mode press with trig_en=1 -> ARMED; with trig_en=0, mode press is ignored.
  - step press is ignored.
- ARMED:
  - led_out<=led_in.
  - hit -> CAPTURED; the hit sample is written as the newest entry.
  - trig_en=0 -> LIVE.
  - mode press -> LIVE and overrides a same-cycle hit (no transition to CAPTURED; the sample is still written as a normal LIVE/ARMED write).
- CAPTURED:
  - Writes stop; led_out<=mem[wptr-1]; hist_idx=0.
  - step press -> BROWSE with hist_idx=1 if hist_count>1; otherwise stays in CAPTURED.
  - mode press -> LIVE.
- BROWSE:
  - led_out<=mem[(wptr-1-hist_idx) mod DEPTH].
  - step press: hist_idx+1; if hist_idx+1==hist_count, wrap to 0 and show newest.
  - mode press -> LIVE with hist_idx=0; history is retained, and writes continue at wptr.
- Mode beats step when both pulse in the same cycle.
- The history read path is registered; led_out updates 1 cycle after a state or hist_idx change.
- hist_idx resets to 0 on every entry to LIVE.

Test Plan:
1. Reset/live: rst=0 for 2 cycles, then led_in=16'hA5A5 -> led_out=0 during reset, 16'hA5A5 one cycle after release, state_out=0.
2. Debounce (DEBOUNCE_CYCLES=4): btn_mode glitch 3 cycles high, then held 20 cycles -> glitch ignored; exactly one press; state_out 0->1 (trig_en=1); no second pulse while held.
3. Trigger: ARMED, trig_value=16'h0040; samples led_in=16'h0001..0005 with trig_pc matching on the 5th -> state_out=2, led_out=16'h0005; a later led_in change does not alter led_out.
4. Browse wrap: after test 3, five step presses -> led_out 0004,0003,0002,0001,0005; hist_idx 1,2,3,4,0.
5. Overflow: 11 samples 16'h0100..010A in LIVE, DEPTH=8, then capture -> hist_count=8; browsing yields 010A down to 0103, then wraps to 010A.
6. Collisions: mode press on the same cycle as hit -> LIVE, not CAPTURED; mode+step together in BROWSE -> LIVE, hist_idx=0; rst=0 while in BROWSE -> all outputs at reset values.

Source files
------------

// File: rtl/dbg_led_capture_if.sv
// LED capture bus: debug word, trigger controls, raw buttons and
// the LED/status outputs, bundled so the consumer sees one port.
interface dbg_led_capture_if #(
    parameter int DEPTH = 8
);
    localparam int IW = $clog2(DEPTH);

    logic [15:0]   led_in;
    logic          sample_en;
    logic          trig_en;
    logic [15:0]   trig_value;
    logic [15:0]   trig_pc;
    logic          btn_mode;
    logic          btn_step;
    logic [15:0]   led_out;
    logic [1:0]    state_out;
    logic [IW-1:0] hist_idx;
    logic [IW:0]   hist_count;

    modport master (
        output led_in, sample_en, trig_en, trig_value, trig_pc,
        output btn_mode, btn_step,
        input  led_out, state_out, hist_idx, hist_count
    );

    modport slave (
        input  led_in, sample_en, trig_en, trig_value, trig_pc,
        input  btn_mode, btn_step,
        output led_out, state_out, hist_idx, hist_count
    );
endinterface

// File: rtl/dbg_led_capture.sv
// Debug LED capture: live pass-through, PC-match freeze and a
// button-browsable circular history of sampled debug words.
module dbg_led_capture_db #(
    parameter int CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic press_o
);
    localparam int CW = $clog2(CYCLES + 1);

    logic          s1_q;
    logic          s2_q;
    logic [CW-1:0] cnt_q;

    // Synchronize, then count stable cycles; reload on any level change.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q <= raw_i;
            s2_q <= s1_q;
            if (s1_q != s2_q) begin
                cnt_q <= '0;
            end else if (cnt_q != CW'(CYCLES)) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    // Saturation at CYCLES keeps a held button to a single pulse.
    assign press_o = s2_q && (cnt_q == CW'(CYCLES - 1));
endmodule

module dbg_led_capture #(
    parameter int DEPTH           = 8,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                     clk,
    input  logic                     rst,
    dbg_led_capture_if.slave         bus
);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        LIVE     = 2'd0,
        ARMED    = 2'd1,
        CAPTURED = 2'd2,
        BROWSE   = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] wptr_q;
    logic [IW:0]   count_q;
    logic [15:0]   led_q, led_d;
    logic [15:0]   mem [DEPTH];

    logic          mode_p;
    logic          step_p;
    logic          hit;
    logic          wr_en;
    logic [IW-1:0] rd_addr;

    dbg_led_capture_db #(.CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk     (clk),
        .rst     (rst),
        .raw_i   (bus.btn_mode),
        .press_o (mode_p)
    );

    dbg_led_capture_db #(.CYCLES(DEBOUNCE_CYCLES)) u_db_step (
        .clk     (clk),
        .rst     (rst),
        .raw_i   (bus.btn_step),
        .press_o (step_p)
    );

    assign hit     = bus.sample_en && (bus.trig_pc == bus.trig_value);
    assign wr_en   = bus.sample_en && (state_q == LIVE || state_q == ARMED);
    assign rd_addr = wptr_q - IW'(1) - idx_q;

    // Next state and browse index; mode press always wins over step.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            LIVE: begin
                idx_d = '0;
                if (mode_p && bus.trig_en) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                idx_d = '0;
                if (mode_p || !bus.trig_en) begin
                    state_d = LIVE;
                end else if (hit) begin
                    state_d = CAPTURED;
                end
            end
            CAPTURED: begin
                idx_d = '0;
                if (mode_p) begin
                    state_d = LIVE;
                end else if (step_p && count_q > (IW+1)'(1)) begin
                    state_d = BROWSE;
                    idx_d   = IW'(1);
                end
            end
            BROWSE: begin
                if (mode_p) begin
                    state_d = LIVE;
                    idx_d   = '0;
                end else if (step_p) begin
                    if ({1'b0, idx_q} + (IW+1)'(1) == count_q) begin
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = LIVE;
                idx_d   = '0;
            end
        endcase
    end

    // Registered LED source: live word, or history at the current index.
    always_comb begin
        led_d = bus.led_in;
        if (state_q == CAPTURED || state_q == BROWSE) begin
            led_d = mem[rd_addr];
        end
    end

    // Control state, write pointer, fill level and LED register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= LIVE;
            idx_q   <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            led_q   <= led_d;
            if (wr_en) begin
                wptr_q <= wptr_q + IW'(1);
                if (count_q != (IW+1)'(DEPTH)) begin
                    count_q <= count_q + (IW+1)'(1);
                end
            end
        end
    end

    // History RAM; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr_q] <= bus.led_in;
        end
    end

    assign bus.led_out    = led_q;
    assign bus.state_out  = state_q;
    assign bus.hist_idx   = idx_q;
    assign bus.hist_count = count_q;
endmodule

// File: tb/tb_dbg_led_capture.sv
// Bench for dbg_led_capture: directed tables, corner sequences and a
// randomized run against a queue-based history model.
module tb_dbg_led_capture;
    localparam int DEPTH = 8;
    localparam int DB    = 4;
    localparam int IW    = 3;
    localparam int NR    = 3000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dbg_led_capture_if #(.DEPTH(DEPTH)) bus ();

    dbg_led_capture #(
        .DEPTH           (DEPTH),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] led_in;
        logic        sample_en;
        logic [15:0] pc;
        logic [15:0] exp_led;
        logic [1:0]  exp_state;
        logic [IW:0] exp_cnt;
    } vec_t;

    typedef struct {
        logic [15:0]   exp_led;
        logic [IW-1:0] exp_idx;
    } bvec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input bit m, input bit s);
        bus.btn_mode = m;
        bus.btn_step = s;
        repeat (DB + 2) tick();
        bus.btn_mode = 1'b0;
        bus.btn_step = 1'b0;
        repeat (4) tick();
    endtask

    task automatic sample(input logic [15:0] d, input logic [15:0] pc);
        bus.led_in    = d;
        bus.trig_pc   = pc;
        bus.sample_en = 1'b1;
        tick();
        bus.sample_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Model state for the randomized run.
    logic [15:0] hq [$];
    bit          rm [NR];
    bit          rs [NR];

    function automatic bit pulse(input int k, input bit is_mode);
        bit v;
        for (int j = 0; j < DB; j++) begin
            if (k - 2 - j < 0) return 1'b0;
            v = is_mode ? rm[k-2-j] : rs[k-2-j];
            if (!v) return 1'b0;
        end
        if (k - 2 - DB < 0) return 1'b1;
        v = is_mode ? rm[k-2-DB] : rs[k-2-DB];
        return !v;
    endfunction

    initial begin
        vec_t  tv [7];
        bvec_t bv [5];
        int    ms;
        int    midx;
        bit    mp, sp, hitv, ten, se, bm, bs;
        logic [15:0] li, pc, eled;

        tv[0] = '{16'h0001, 1'b1, 16'h0000, 16'h0001, 2'd1, 4'd1};
        tv[1] = '{16'h0002, 1'b1, 16'h0000, 16'h0002, 2'd1, 4'd2};
        tv[2] = '{16'h0003, 1'b1, 16'h0011, 16'h0003, 2'd1, 4'd3};
        tv[3] = '{16'h0004, 1'b1, 16'h0000, 16'h0004, 2'd1, 4'd4};
        tv[4] = '{16'h0005, 1'b1, 16'h0040, 16'h0005, 2'd2, 4'd5};
        tv[5] = '{16'hFFFF, 1'b0, 16'h0040, 16'h0005, 2'd2, 4'd5};
        tv[6] = '{16'h1234, 1'b1, 16'h0040, 16'h0005, 2'd2, 4'd5};

        bv[0] = '{16'h0004, 3'd1};
        bv[1] = '{16'h0003, 3'd2};
        bv[2] = '{16'h0002, 3'd3};
        bv[3] = '{16'h0001, 3'd4};
        bv[4] = '{16'h0005, 3'd0};

        bus.led_in     = 16'hA5A5;
        bus.sample_en  = 1'b0;
        bus.trig_en    = 1'b1;
        bus.trig_value = 16'h0040;
        bus.trig_pc    = 16'h0000;
        bus.btn_mode   = 1'b0;
        bus.btn_step   = 1'b0;

        // Reset and live pass-through
        rst = 1'b0;
        tick();
        chk("rst_led_a", 32'(bus.led_out), 32'h0);
        tick();
        chk("rst_led_b", 32'(bus.led_out), 32'h0);
        chk("rst_state", 32'(bus.state_out), 32'd0);
        chk("rst_cnt", 32'(bus.hist_count), 32'd0);
        chk("rst_idx", 32'(bus.hist_idx), 32'd0);
        rst = 1'b1;
        tick();
        chk("live_led", 32'(bus.led_out), 32'hA5A5);
        chk("live_state", 32'(bus.state_out), 32'd0);

        // Debounce: glitch ignored, one press, latency, no repeat
        bus.btn_mode = 1'b1;
        repeat (3) tick();
        bus.btn_mode = 1'b0;
        repeat (6) tick();
        chk("glitch_state", 32'(bus.state_out), 32'd0);
        bus.btn_mode = 1'b1;
        repeat (DB + 1) tick();
        chk("press_early", 32'(bus.state_out), 32'd0);
        tick();
        chk("press_armed", 32'(bus.state_out), 32'd1);
        repeat (20 - DB - 2) tick();
        chk("held_no_repeat", 32'(bus.state_out), 32'd1);
        bus.btn_mode = 1'b0;
        repeat (4) tick();

        // Trigger capture table
        for (int i = 0; i < 7; i++) begin
            bus.led_in    = tv[i].led_in;
            bus.sample_en = tv[i].sample_en;
            bus.trig_pc   = tv[i].pc;
            tick();
            chk($sformatf("trig_led[%0d]", i),
                32'(bus.led_out), 32'(tv[i].exp_led));
            chk($sformatf("trig_state[%0d]", i),
                32'(bus.state_out), 32'(tv[i].exp_state));
            chk($sformatf("trig_cnt[%0d]", i),
                32'(bus.hist_count), 32'(tv[i].exp_cnt));
        end
        bus.sample_en = 1'b0;

        // Browse with wrap
        for (int i = 0; i < 5; i++) begin
            press(1'b0, 1'b1);
            chk($sformatf("brw_led[%0d]", i),
                32'(bus.led_out), 32'(bv[i].exp_led));
            chk($sformatf("brw_idx[%0d]", i),
                32'(bus.hist_idx), 32'(bv[i].exp_idx));
            chk($sformatf("brw_state[%0d]", i),
                32'(bus.state_out), 32'd3);
        end

        // Overflow: 11 samples into an 8-deep history
        press(1'b1, 1'b0);
        chk("ovf_live", 32'(bus.state_out), 32'd0);
        chk("ovf_idx0", 32'(bus.hist_idx), 32'd0);
        for (int i = 0; i < 10; i++) begin
            sample(16'h0100 + 16'(i), 16'h0000);
            chk($sformatf("ovf_pass[%0d]", i),
                32'(bus.led_out), 32'h0100 + 32'(i));
        end
        chk("ovf_cnt_sat", 32'(bus.hist_count), 32'd8);
        press(1'b1, 1'b0);
        chk("ovf_armed", 32'(bus.state_out), 32'd1);
        sample(16'h010A, 16'h0040);
        chk("ovf_capt", 32'(bus.state_out), 32'd2);
        tick();
        chk("ovf_newest", 32'(bus.led_out), 32'h010A);
        chk("ovf_cnt", 32'(bus.hist_count), 32'd8);
        for (int k = 1; k <= 8; k++) begin
            press(1'b0, 1'b1);
            chk($sformatf("ovf_brw_led[%0d]", k), 32'(bus.led_out),
                (k == 8) ? 32'h010A : 32'h010A - 32'(k));
            chk($sformatf("ovf_brw_idx[%0d]", k), 32'(bus.hist_idx),
                (k == 8) ? 32'd0 : 32'(k));
        end

        // Mode press colliding with a hit
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        chk("col_armed", 32'(bus.state_out), 32'd1);
        bus.btn_mode = 1'b1;
        repeat (DB + 1) tick();
        sample(16'h0BEE, 16'h0040);
        chk("col_mode_hit", 32'(bus.state_out), 32'd0);
        bus.btn_mode = 1'b0;
        repeat (4) tick();

        // Mode and step together in BROWSE
        press(1'b1, 1'b0);
        sample(16'h0C01, 16'h0040);
        chk("col_capt", 32'(bus.state_out), 32'd2);
        press(1'b0, 1'b1);
        chk("col_brw_led1", 32'(bus.led_out), 32'h0BEE);
        press(1'b0, 1'b1);
        chk("col_brw_led2", 32'(bus.led_out), 32'h010A);
        chk("col_brw_idx2", 32'(bus.hist_idx), 32'd2);
        press(1'b1, 1'b1);
        chk("col_both_state", 32'(bus.state_out), 32'd0);
        chk("col_both_idx", 32'(bus.hist_idx), 32'd0);

        // Reset mid-browse and mid-debounce
        press(1'b1, 1'b0);
        sample(16'h0C02, 16'h0040);
        press(1'b0, 1'b1);
        chk("rb_browse", 32'(bus.state_out), 32'd3);
        bus.btn_mode = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rb_led", 32'(bus.led_out), 32'h0);
        chk("rb_state", 32'(bus.state_out), 32'd0);
        chk("rb_idx", 32'(bus.hist_idx), 32'd0);
        chk("rb_cnt", 32'(bus.hist_count), 32'd0);
        rst = 1'b1;
        repeat (DB + 1) tick();
        chk("rb_press_early", 32'(bus.state_out), 32'd0);
        tick();
        chk("rb_press", 32'(bus.state_out), 32'd1);
        bus.btn_mode = 1'b0;
        repeat (4) tick();

        // Randomized run against the history model
        rst = 1'b0;
        tick();
        rst = 1'b1;
        hq.delete();
        ms   = 0;
        midx = 0;
        bm   = 1'b0;
        bs   = 1'b0;
        for (int k = 0; k < NR; k++) begin
            if ($urandom_range(0, 5) == 0) bm = !bm;
            if ($urandom_range(0, 4) == 0) bs = !bs;
            se  = ($urandom_range(0, 1) == 1);
            ten = ($urandom_range(0, 15) != 0);
            li  = 16'($urandom);
            pc  = ($urandom_range(0, 3) == 0) ? 16'h0040 : 16'($urandom);
            rm[k] = bm;
            rs[k] = bs;
            mp   = pulse(k, 1'b1);
            sp   = pulse(k, 1'b0);
            hitv = se && (pc == 16'h0040);

            eled = (ms < 2) ? li : hq[midx];
            if (ms < 2 && se) begin
                hq.push_front(li);
                if (hq.size() > DEPTH) void'(hq.pop_back());
            end
            case (ms)
                0: begin
                    midx = 0;
                    if (mp && ten) ms = 1;
                end
                1: begin
                    if (mp || !ten) ms = 0;
                    else if (hitv) ms = 2;
                end
                2: begin
                    if (mp) ms = 0;
                    else if (sp && hq.size() > 1) begin
                        ms   = 3;
                        midx = 1;
                    end
                end
                default: begin
                    if (mp) begin
                        ms   = 0;
                        midx = 0;
                    end else if (sp) begin
                        midx = (midx + 1 == hq.size()) ? 0 : midx + 1;
                    end
                end
            endcase

            bus.btn_mode  = bm;
            bus.btn_step  = bs;
            bus.sample_en = se;
            bus.trig_en   = ten;
            bus.led_in    = li;
            bus.trig_pc   = pc;
            tick();
            chk($sformatf("rnd_led[%0d]", k), 32'(bus.led_out), 32'(eled));
            chk($sformatf("rnd_state[%0d]", k),
                32'(bus.state_out), 32'(ms));
            chk($sformatf("rnd_idx[%0d]", k), 32'(bus.hist_idx), 32'(midx));
            chk($sformatf("rnd_cnt[%0d]", k),
                32'(bus.hist_count), 32'(hq.size()));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
